// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace debugger and its output stream buffer.
package trdb_pkg;
    localparam int XLEN           = 32;
    localparam int TRDB_CNTW      = 16;
    localparam int TRDB_BUF_DEPTH = 16;

    // Upper half of an overflow marker word; the lower half carries the drop count.
    localparam logic [XLEN-TRDB_CNTW-1:0] TRDB_OVF_TAG = 16'hF0F0;

    typedef logic [TRDB_CNTW-1:0] trdb_drop_cnt_t;

    typedef enum logic {
        BUF_IDLE,
        BUF_PENDING
    } trdb_buf_state_e;
endpackage

// File: rtl/trdb_sync_fifo.sv
// Generic show-ahead synchronous FIFO; the caller guarantees push only when space is available.
module trdb_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/trdb_stream_buffer.sv
// Absorbs the non-backpressured trace word stream, drains it over valid/ready,
// and replaces each run of dropped words with one in-band overflow marker.
module trdb_stream_buffer #(
    parameter int XLEN  = trdb_pkg::XLEN,
    parameter int DEPTH = trdb_pkg::TRDB_BUF_DEPTH,
    parameter int CNTW  = trdb_pkg::TRDB_CNTW
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [XLEN-1:0]          packet_word_i,
    input  logic                     packet_word_valid_i,
    output logic [XLEN-1:0]          word_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic [$clog2(DEPTH):0]   fill_level_o,
    output logic                     almost_full_o,
    output logic                     overflow_o,
    output logic [CNTW-1:0]          dropped_cnt_o
);
    import trdb_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-CNTW-1:0] OVF_TAG = (XLEN-CNTW)'(TRDB_OVF_TAG);
    localparam logic [AW:0]          AF_LVL  = (AW+1)'(DEPTH-2);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    trdb_buf_state_e state, state_n;
    logic [CNTW-1:0] drop_run, drop_run_n;
    logic [CNTW-1:0] dropped_n;
    logic            overflow_n;
    logic            wr_en;
    logic [XLEN-1:0] wr_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            space;
    logic            in;

    assign in           = enable_i && packet_word_valid_i;
    assign word_valid_o = !fifo_empty;
    assign pop          = word_valid_o && word_ready_i;
    // A full FIFO that pops this cycle frees the slot being written.
    assign space        = !fifo_full || pop;
    assign almost_full_o = (fill_level_o >= AF_LVL);

    trdb_sync_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (clear_i),
        .push  (wr_en),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (word_o),
        .count (fill_level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state         <= BUF_IDLE;
            drop_run      <= '0;
            dropped_cnt_o <= '0;
            overflow_o    <= 1'b0;
        end else begin
            state         <= state_n;
            drop_run      <= drop_run_n;
            dropped_cnt_o <= dropped_n;
            overflow_o    <= overflow_n;
        end
    end

    always_comb begin
        state_n    = state;
        drop_run_n = drop_run;
        dropped_n  = dropped_cnt_o;
        overflow_n = overflow_o;
        wr_en      = 1'b0;
        wr_data    = packet_word_i;
        case (state)
            BUF_PENDING: begin
                // The marker owns the write port; any coincident word joins this episode.
                if (space) begin
                    wr_en      = 1'b1;
                    wr_data    = {OVF_TAG, in ? sat_inc(drop_run) : drop_run};
                    if (in) dropped_n = sat_inc(dropped_cnt_o);
                    drop_run_n = '0;
                    state_n    = BUF_IDLE;
                end else if (in) begin
                    drop_run_n = sat_inc(drop_run);
                    dropped_n  = sat_inc(dropped_cnt_o);
                end
            end
            default: begin
                if (in) begin
                    if (space) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_run_n = CNTW'(1);
                        dropped_n  = sat_inc(dropped_cnt_o);
                        overflow_n = 1'b1;
                        state_n    = BUF_PENDING;
                    end
                end
            end
        endcase
    end
endmodule
